// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer: opcode classes, FSM states,
// mux selects and trap error codes.
package seq_pkg;

    localparam logic [3:0] OP_ALUR  = 4'b0000;
    localparam logic [3:0] OP_ALUI  = 4'b1000;
    localparam logic [3:0] OP_CMPR  = 4'b0010;
    localparam logic [3:0] OP_CMPI  = 4'b1010;
    localparam logic [3:0] OP_LW    = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BCOND = 4'b0110;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JAL    = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_ALUR) || (op == OP_ALUI) || (op == OP_CMPR) ||
               (op == OP_CMPI) || (op == OP_LW)   || (op == OP_JAL)  ||
               (op == OP_SW)   || (op == OP_BCOND);
    endfunction

    // Classes whose second ALU operand is the sign-extended immediate.
    function automatic logic op_uses_imm(input logic [3:0] op);
        return (op == OP_ALUI) || (op == OP_CMPI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts cycles spent waiting for a memory ack and flags the cycle in which
// the wait limit is hit with the ack still low. TIMEOUT of 0 disables it.
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ENABLED = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = ENABLED && active && !ack && (cnt_q == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback
// sequencing with req/ack memory handshakes, a sticky trap and a retire counter.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           op1,
    input  logic                 cond_true,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_b_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [1:0]           err_code,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    state_t               state_q, state_d;
    logic [1:0]           err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic wait_active;
    logic wait_ack;
    logic wait_clear;
    logic wait_expired;

    // Acks are only meaningful while the matching request is up.
    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_ack    = (state_q == ST_FETCH) ? imem_ack : dmem_ack;
    assign wait_clear  = (state_d != state_q);

    seq_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .active (wait_active),
        .ack    (wait_ack),
        .expired(wait_expired)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        trap      = 1'b0;
        err_code  = ERR_NONE;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (!op_legal(op1)) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_b_sel = op_uses_imm(op1);
                if (op1 == OP_BCOND) begin
                    pc_we   = 1'b1;
                    pc_sel  = cond_true ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    state_d = ST_FETCH;
                end else if ((op1 == OP_LW) || (op1 == OP_SW)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (op1 == OP_SW);
                alu_b_sel = 1'b1;
                if (dmem_ack) begin
                    if (op1 == OP_SW) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op1 == OP_LW) ? WB_SEL_MEM :
                          (op1 == OP_JAL) ? WB_SEL_PC4 : WB_SEL_ALU;
                pc_we   = 1'b1;
                pc_sel  = (op1 == OP_JAL) ? PC_SEL_JAL : PC_SEL_PLUS4;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trap     = 1'b1;
                err_code = err_q;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Reset silences every output in the same cycle, abandoning any request.
        if (reset) begin
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = PC_SEL_PLUS4;
            alu_b_sel = 1'b0;
            reg_we    = 1'b0;
            wb_sel    = WB_SEL_ALU;
            trap      = 1'b0;
            err_code  = ERR_NONE;
        end

        cnt_d = cnt_q + CNT_WIDTH'(pc_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign retire_cnt = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Lockstep bench: each instruction is expanded into its expected per-cycle
// output pattern from the class rules, then compared against the sequencer.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int TO = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    op1;
    logic          cond_true;
    logic          imem_ack;
    logic          dmem_ack;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]    pc_sel;
    logic          alu_b_sel, reg_we;
    logic [1:0]    wb_sel;
    logic          trap;
    logic [1:0]    err_code;
    logic [CW-1:0] retire_cnt;

    typedef struct packed {
        logic          imem_req;
        logic          dmem_req;
        logic          dmem_we;
        logic          ir_we;
        logic          pc_we;
        logic [1:0]    pc_sel;
        logic          alu_b_sel;
        logic          reg_we;
        logic [1:0]    wb_sel;
        logic          trap;
        logic [1:0]    err_code;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t act;
    assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_b_sel,
                  reg_we, wb_sel, trap, err_code, retire_cnt};

    instr_sequencer #(.TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .op1(op1), .cond_true(cond_true),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_b_sel(alu_b_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .err_code(err_code),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            steps;
    logic [CW-1:0] m_cnt;

    localparam logic [3:0] LEGAL_OPS [8] = '{OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI,
                                             OP_LW, OP_JAL, OP_SW, OP_BCOND};

    function automatic bit is_legal(input logic [3:0] op);
        foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t base();
        obs_t o = '0;
        o.cnt = m_cnt;
        return o;
    endfunction

    // One cycle: inputs were set after the falling edge; compare, then clock.
    task automatic step(input obs_t e, input string name);
        #1;
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: dut=%h model=%h (t=%0t)", name, act, e, $time);
        end
        @(posedge clk);
        steps++;
        if (e.pc_we) m_cnt = m_cnt + 1'b1;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic noise();
        imem_ack  = 1'($urandom_range(0, 1));
        dmem_ack  = 1'($urandom_range(0, 1));
        cond_true = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        noise();
        step('0, "in_reset");
        reset = 1'b0;
        m_cnt = '0;
    endtask

    task automatic trap_check(input logic [1:0] err, input int n);
        obs_t o;
        for (int i = 0; i < n; i++) begin
            noise();
            o = base();
            o.trap = 1'b1;
            o.err_code = err;
            step(o, "trap_hold");
        end
    endtask

    // err_out: 0 = completed or reset, otherwise the expected trap code.
    task automatic run_instr(input logic [3:0] op, input int df, input int dm,
                             input logic cond, input int rst_at,
                             output logic [1:0] err_out);
        obs_t o;
        err_out = ERR_NONE;
        steps = 0;
        for (int i = 0; ; i++) begin
            imem_ack  = (i == df);
            dmem_ack  = 1'($urandom_range(0, 1));
            cond_true = 1'($urandom_range(0, 1));
            o = base();
            o.imem_req = 1'b1;
            if (i == df) begin
                o.ir_we = 1'b1;
                step(o, "fetch_ack");
                break;
            end
            step(o, "fetch_wait");
            if (i == TO - 1) begin
                err_out = ERR_TIMEOUT;
                return;
            end
        end
        op1 = op;
        noise();
        step(base(), "decode");
        if (!is_legal(op)) begin
            err_out = ERR_ILLEGAL;
            return;
        end
        noise();
        cond_true = cond;
        o = base();
        o.alu_b_sel = (op == OP_ALUI) || (op == OP_CMPI) || (op == OP_LW) || (op == OP_SW);
        if (op == OP_BCOND) begin
            o.pc_we  = 1'b1;
            o.pc_sel = cond ? PC_SEL_BRANCH : PC_SEL_PLUS4;
            step(o, "exec_branch");
            return;
        end
        step(o, "exec");
        if ((op == OP_LW) || (op == OP_SW)) begin
            for (int i = 0; ; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    return;
                end
                dmem_ack  = (i == dm);
                imem_ack  = 1'($urandom_range(0, 1));
                cond_true = 1'($urandom_range(0, 1));
                o = base();
                o.dmem_req  = 1'b1;
                o.dmem_we   = (op == OP_SW);
                o.alu_b_sel = 1'b1;
                if (i == dm) begin
                    o.pc_we = (op == OP_SW);
                    step(o, "mem_ack");
                    if (op == OP_SW) return;
                    break;
                end
                step(o, "mem_wait");
                if (i == TO - 1) begin
                    err_out = ERR_TIMEOUT;
                    return;
                end
            end
        end
        noise();
        o = base();
        o.reg_we = 1'b1;
        o.wb_sel = (op == OP_LW) ? WB_SEL_MEM : (op == OP_JAL) ? WB_SEL_PC4 : WB_SEL_ALU;
        o.pc_we  = 1'b1;
        o.pc_sel = (op == OP_JAL) ? PC_SEL_JAL : PC_SEL_PLUS4;
        step(o, "writeback");
    endtask

    task automatic settle(input logic [1:0] err);
        if (err != ERR_NONE) begin
            trap_check(err, $urandom_range(1, 3));
            do_reset();
        end
    endtask

    logic [1:0] err;

    initial begin
        m_cnt     = '0;
        reset     = 1'b1;
        op1       = 4'h0;
        cond_true = 1'b0;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        @(negedge clk);
        step('0, "in_reset");
        do_reset();

        run_instr(OP_ALUR, 0, 0, 1'b0, -1, err);
        chk("alur_cycles", steps, 4);
        #1 chk("alur_retire", int'(retire_cnt), 1);
        chk("alur_imem_req_next", int'(imem_req), 1);

        run_instr(OP_LW, 0, 3, 1'b0, -1, err);
        chk("lw_cycles", steps, 8);

        run_instr(OP_BCOND, 0, 0, 1'b1, -1, err);
        chk("bcond_t_cycles", steps, 3);
        run_instr(OP_BCOND, 0, 0, 1'b0, -1, err);
        chk("bcond_f_cycles", steps, 3);
        #1 chk("retire_after_4", int'(retire_cnt), 4);

        run_instr(4'b1111, 0, 0, 1'b0, -1, err);
        chk("illegal_err", int'(err), 1);
        trap_check(ERR_ILLEGAL, 4);
        do_reset();

        run_instr(OP_ALUR, 20, 0, 1'b0, -1, err);
        chk("fetch_timeout_err", int'(err), 2);
        trap_check(ERR_TIMEOUT, 3);
        do_reset();

        run_instr(OP_ALUR, TO - 1, 0, 1'b0, -1, err);
        chk("ack_at_limit_cycles", steps, 7);

        run_instr(OP_SW, 0, 3, 1'b0, 1, err);
        #1 chk("sw_reset_retire", int'(retire_cnt), 0);
        run_instr(OP_SW, 0, 0, 1'b0, -1, err);
        chk("sw_cycles", steps, 4);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] op;
            int df, dm, ra;
            op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15))
                                              : LEGAL_OPS[$urandom_range(0, 7)];
            df = ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            dm = ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
            ra = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
            run_instr(op, df, dm, 1'($urandom_range(0, 1)), ra, err);
            settle(err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control FSM that sequences the processor datapath around the instruction decoder. It issues instruction- and data-memory requests with a req/ack handshake and loads the instruction register. It steers ALU operand, writeback and PC-source muxes per instruction class (`op1` from the decoder), and counts retired instructions. An illegal opcode or a memory timeout sends it to a sticky trap state.

## Interface
Parameters:
- `TIMEOUT`, 16: max wait cycles for any ack; 0 disables the timeout.
- `CNT_WIDTH`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `op1`  in  4  primary opcode from the decoder; driven from the registered IR, so stable from DECODE onward.
- `cond_true`  in  1  branch condition result from the ALU, valid in EXEC.
- `imem_ack`  in  1  instruction memory has data this cycle.
- `dmem_ack`  in  1  data memory has completed the access this cycle.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `ir_we`  out  1  load the instruction register.
- `pc_we`  out  1  update the PC.
- `pc_sel`  out  2  0 = PC+4, 1 = branch target, 2 = JAL target.
- `alu_b_sel`  out  1  0 = rs2 register, 1 = sign-extended imm16.
- `reg_we`  out  1  register file write.
- `wb_sel`  out  2  0 = ALU result, 1 = memory data, 2 = PC+4.
- `trap`  out  1  sticky; the FSM is in TRAP.
- `err_code`  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
- `retire_cnt`  out  CNT_WIDTH  number of retired instructions.

## Operation
- Opcode classes (`op1`): ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, LW 1001, JAL 1011, SW 0101, BCOND 0110. Any other value is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - `imem_req`=1 until the ack arrives.
  - On `imem_ack`: `ir_we`=1 and go to DECODE.
- DECODE: one cycle. Illegal `op1` → TRAP with `err_code`=1. Otherwise → EXEC.
- EXEC:
  - `alu_b_sel`=1 for ALUI, CMPI, LW and SW; 0 otherwise.
  - ALUR, ALUI, CMPR, CMPI, JAL → WB.
  - LW, SW → MEM.
  - BCOND: `pc_we`=1, `pc_sel`=`cond_true` ? 1 : 0, then → FETCH.
- MEM:
  - `dmem_req`=1 and `dmem_we`=(SW); hold `alu_b_sel`=1.
  - On `dmem_ack`, LW → WB.
  - On `dmem_ack`, SW → FETCH with `pc_we`=1 and `pc_sel`=0.
- WB:
  - `reg_we`=1.
  - `wb_sel`: 1 for LW, 2 for JAL, 0 otherwise.
  - `pc_we`=1; `pc_sel`=2 for JAL, 0 otherwise.
  - Then → FETCH.
- TRAP: all strobes are 0 and `trap`=1. Only `reset` exits TRAP.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments each cycle in which the ack is low.
  - When `TIMEOUT`≠0 and the counter reaches `TIMEOUT`-1 with the ack still low, the next state is TRAP with `err_code`=2.
  - If the ack arrives in the same cycle the limit is reached, the ack wins.
- `retire_cnt` increments by 1 in every cycle where `pc_we`=1. It wraps modulo 2^CNT_WIDTH.
- Output style:
  - `imem_req`, `dmem_req`, `dmem_we`, `trap` and `err_code` are Moore outputs (decoded from state).
  - `ir_we`, `pc_we`, `pc_sel`, `reg_we`, `wb_sel` and `alu_b_sel` are decoded from state plus `op1`, `cond_true` and the ack inputs.

## Timing
- Reset:
  - While `reset`=1, every output is forced to 0.
  - On the reset edge: state→FETCH, wait counter→0, `retire_cnt`→0, `err_code`→0.
  - The first cycle after reset has `imem_req`=1.
- Reset mid-operation abandons the instruction. Requests drop in the same cycle, with no completion strobe.
- An ack in the first cycle of a request is legal (zero wait).
- The requester holds `req` high until the ack. An ack while `req` is low is ignored.
- Minimum latency, FETCH entry to next FETCH, with zero-wait memory:
  - BCOND: 3 cycles.
  - ALU, CMP, JAL, SW: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds one cycle.

## Structure
- Shared package `seq_pkg`:
  - `op1` class localparams.
  - State enum encoding.
  - `pc_sel` and `wb_sel` encodings.
  - `err_code` values.
- Natural sub-module: `seq_wait_timer`, the wait counter plus timeout compare, parameterized by `TIMEOUT`.
- The top level holds the FSM, output decode and `retire_cnt`.

## Test plan
- ALUR, zero-wait memory → `imem_req` 1 cycle, `ir_we` pulse, then `reg_we`=1 with `wb_sel`=0 and `pc_we`=1 with `pc_sel`=0 in cycle 4; `retire_cnt` 0→1.
- LW with `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0, then WB with `wb_sel`=1; total 8 cycles.
- BCOND with `cond_true`=1, then again with `cond_true`=0 → `pc_sel`=1 and then 0 in EXEC; each takes 3 cycles; `reg_we` never asserted.
- `op1`=1111 → TRAP after DECODE, `trap`=1, `err_code`=1, no further `imem_req`; after `reset`, `imem_req`=1 with `err_code`=0.
- `TIMEOUT`=4 with `imem_ack` never asserted → TRAP, `err_code`=2. A second run with the ack arriving exactly at the limit cycle → normal DECODE.
- Assert `reset` during MEM of an SW → `dmem_req` drops immediately, no `pc_we`, `retire_cnt`=0; the cycle after reset has FETCH with `imem_req`=1.
